// File: rtl/main_mem_initiator_pkg.sv
// Shared bus package: module-select codes, main memory geometry, initiator FSM
// states and the command word carried through the optional command queue.
package main_mem_initiator_pkg;

  localparam logic [3:0] RomEn     = 4'h0;
  localparam logic [3:0] MainMemEn = 4'h1;
  localparam logic [3:0] IoEn      = 4'h2;

  localparam int unsigned MAIN_MEM_DEPTH = 14;
  localparam int unsigned CMD_W          = 269;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic         write;
    logic [11:0]  offset;
    logic [255:0] wdata;
  } cmd_t;

  function automatic logic offset_in_range(input logic [11:0] offset, input int unsigned depth);
    return 32'(offset) < depth;
  endfunction

endpackage

// File: rtl/main_mem_initiator_cmd_fifo2.sv
// Two-entry command FIFO placed ahead of the initiator FSM when the command
// queue is enabled; push and pop may happen on the same edge.
module cmd_fifo2
  import main_mem_initiator_pkg::*;
(
  input  logic clk,
  input  logic n_reset,
  input  logic push,
  input  cmd_t push_data,
  output logic full,
  input  logic pop,
  output logic head_valid,
  output cmd_t head_data
);

  cmd_t       mem_q [2];
  cmd_t       mem_d [2];
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       do_push, do_pop;

  assign full       = (count_q == 2'd2);
  assign head_valid = (count_q != 2'd0);
  assign head_data  = mem_q[rd_ptr_q];
  assign do_push    = push && !full;
  assign do_pop     = pop && head_valid;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mem_q[0] <= cmd_t'(269'd0);
      mem_q[1] <= cmd_t'(269'd0);
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/main_mem_initiator.sv
// CPU-side initiator for main memory: one strobe cycle per command, one response
// pulse per command. Define MAIN_MEM_INIT_QUEUE_EN to add a 2-entry command FIFO.
module main_mem_initiator
  import main_mem_initiator_pkg::*;
#(
  parameter int unsigned DEPTH = MAIN_MEM_DEPTH
) (
  input  logic         Clk,
  input  logic         nReset,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_write,
  input  logic [11:0]  req_offset,
  input  logic [255:0] req_wdata,
  output logic         rsp_valid,
  output logic [255:0] rsp_rdata,
  output logic         rsp_err,
  output logic         nRead,
  output logic         nWrite,
  output logic [15:0]  address,
  output logic [255:0] BusDataOut,
  input  logic [255:0] BusDataIn
);

  localparam logic [3:0] MEM_SEL = MainMemEn;

  state_e       state_q, state_d;
  logic         nread_q, nread_d, nwrite_q, nwrite_d;
  logic [15:0]  address_q, address_d;
  logic [255:0] bus_dout_q, bus_dout_d;
  logic [255:0] rsp_rdata_q, rsp_rdata_d;
  logic         rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic         op_write_q, op_write_d, op_err_q, op_err_d;
  logic         cmd_valid, launch, launch_err;
  cmd_t         cmd;

  assign launch     = cmd_valid && ((state_q == IDLE) || (state_q == RESP));
  assign launch_err = !offset_in_range(cmd.offset, DEPTH);

`ifdef MAIN_MEM_INIT_QUEUE_EN
  logic fifo_full;

  cmd_fifo2 u_cmd_fifo2 (
    .clk        (Clk),
    .n_reset    (nReset),
    .push       (req_valid),
    .push_data  ({req_write, req_offset, req_wdata}),
    .full       (fifo_full),
    .pop        (launch),
    .head_valid (cmd_valid),
    .head_data  (cmd)
  );

  assign req_ready = !fifo_full;
`else
  assign cmd_valid = req_valid;
  assign cmd       = {req_write, req_offset, req_wdata};
  assign req_ready = (state_q == IDLE) || (state_q == RESP);
`endif

  // Out-of-range commands still walk BUS->RESP so every command gets a response.
  always_comb begin
    state_d     = state_q;
    nread_d     = 1'b1;
    nwrite_d    = 1'b1;
    address_d   = address_q;
    bus_dout_d  = bus_dout_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    op_write_d  = op_write_q;
    op_err_d    = op_err_q;
    case (state_q)
      IDLE, RESP: begin
        if (launch) begin
          state_d    = BUS;
          address_d  = {MEM_SEL, cmd.offset};
          op_write_d = cmd.write;
          op_err_d   = launch_err;
          if (launch_err) begin
            nread_d  = 1'b1;
            nwrite_d = 1'b1;
          end else if (cmd.write) begin
            nwrite_d   = 1'b0;
            bus_dout_d = cmd.wdata;
          end else begin
            nread_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      BUS: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = op_err_q;
        if (!op_err_q && !op_write_q) begin
          rsp_rdata_d = BusDataIn;
        end else begin
          rsp_rdata_d = rsp_rdata_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      nread_q     <= 1'b1;
      nwrite_q    <= 1'b1;
      address_q   <= 16'd0;
      bus_dout_q  <= 256'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 256'd0;
      op_write_q  <= 1'b0;
      op_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      nread_q     <= nread_d;
      nwrite_q    <= nwrite_d;
      address_q   <= address_d;
      bus_dout_q  <= bus_dout_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      op_write_q  <= op_write_d;
      op_err_q    <= op_err_d;
    end
  end

  assign nRead      = nread_q;
  assign nWrite     = nwrite_q;
  assign address    = address_q;
  assign BusDataOut = bus_dout_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_rdata  = rsp_rdata_q;

endmodule

// File: tb/tb_main_mem_initiator.sv
// Self-checking bench for main_mem_initiator with a behavioural main memory
// responder; builds with or without MAIN_MEM_INIT_QUEUE_EN.
module tb_main_mem_initiator;
  import main_mem_initiator_pkg::*;

`ifdef MAIN_MEM_INIT_QUEUE_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic         Clk = 1'b0;
  logic         nReset;
  logic         req_valid, req_ready, req_write;
  logic [11:0]  req_offset;
  logic [255:0] req_wdata;
  logic         rsp_valid, rsp_err;
  logic [255:0] rsp_rdata;
  logic         nRead, nWrite;
  logic [15:0]  address;
  logic [255:0] BusDataOut;
  logic [255:0] BusDataIn = 256'd0;

  main_mem_initiator dut (
    .Clk(Clk), .nReset(nReset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_offset(req_offset), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .nRead(nRead), .nWrite(nWrite), .address(address),
    .BusDataOut(BusDataOut), .BusDataIn(BusDataIn)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] init_val(input int i);
    case (i)
      0:       return 256'h0008_000c_0008_0006_000c_0010_000d_0009_000a_0009_0005_000d_000c_0003_000a_0006;
      10:      return 256'h6;
      11:      return 256'hd;
      default: return {8{32'hA5A5_0000 | 32'(i)}};
    endcase
  endfunction

  // Behavioural main memory: samples strobes on the negedge of the strobe cycle.
  logic [255:0] wmem [14];
  logic [13:0]  written = 14'd0;
  always @(negedge Clk) begin
    if (address[15:12] == MainMemEn && address[11:0] < 12'd14) begin
      if (!nWrite) begin
        wmem[address[3:0]]    <= BusDataOut;
        written[address[3:0]] <= 1'b1;
      end
      if (!nRead) BusDataIn <= written[address[3:0]] ? wmem[address[3:0]] : init_val(int'(address[3:0]));
    end
  end

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int           rd_strobes = 0;
  int           wr_strobes = 0;
  logic         prev_low = 1'b0;
  logic [255:0] rsp_data_q [$];
  logic         rsp_err_q [$];
  int           rsp_cyc_q [$];

  // Bus monitor: collects responses and checks strobe shape and address.
  always @(negedge Clk) begin
    if (rsp_valid) begin
      rsp_data_q.push_back(rsp_rdata);
      rsp_err_q.push_back(rsp_err);
      rsp_cyc_q.push_back(cyc);
    end
    if (!nRead || !nWrite) begin
      check("one_strobe", 256'(nRead ^ nWrite), 256'd1);
      check("strobe_gap", 256'(prev_low), 256'd0);
      check("addr_sel", 256'(address[15:12]), 256'(MainMemEn));
      check("addr_range", 256'(address[11:0] < 12'd14), 256'd1);
      if (!nRead) rd_strobes++;
      if (!nWrite) wr_strobes++;
    end
    prev_low = !(nRead && nWrite);
  end

  task automatic issue(input logic w, input logic [11:0] off, input logic [255:0] wd, output int acc);
    acc = -1;
    @(negedge Clk);
    req_valid = 1'b1; req_write = w; req_offset = off; req_wdata = wd;
    for (int n = 0; n < 20 && acc < 0; n++) begin
      #1;
      if (req_ready) begin
        @(posedge Clk);
        acc = cyc;
      end else begin
        @(negedge Clk);
      end
    end
    #1 req_valid = 1'b0;
    check("accept_timeout", 256'(acc >= 0), 256'd1);
  endtask

  task automatic wait_rsp(output logic [255:0] d, output logic e, output int c);
    d = 256'd0; e = 1'b0; c = -100;
    for (int n = 0; n < 20 && rsp_data_q.size() == 0; n++) @(posedge Clk);
    check("rsp_timeout", 256'(rsp_data_q.size() > 0), 256'd1);
    if (rsp_data_q.size() > 0) begin
      d = rsp_data_q.pop_front();
      e = rsp_err_q.pop_front();
      c = rsp_cyc_q.pop_front();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_nRead"}, 256'(nRead), 256'd1);
    check({tag, "_nWrite"}, 256'(nWrite), 256'd1);
    check({tag, "_address"}, 256'(address), 256'd0);
    check({tag, "_BusDataOut"}, BusDataOut, 256'd0);
    check({tag, "_rsp_valid"}, 256'(rsp_valid), 256'd0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 256'd0);
    check({tag, "_rsp_err"}, 256'(rsp_err), 256'd0);
  endtask

  typedef struct {
    logic         w;
    logic [11:0]  off;
    logic [255:0] wd;
    logic         exp_err;
    logic [255:0] exp_rdata;
  } vec_t;

  vec_t         vecs [8];
  logic         s_w [3];
  logic [11:0]  s_off [3];
  logic [255:0] s_wd [3];
  int           s_acc [3];

  initial begin
    logic [255:0] d;
    logic         e;
    int           c, acc, r0, w0, idx, rdy;

    vecs[0] = '{1'b0, 12'h000, 256'd0, 1'b0, init_val(0)};
    vecs[1] = '{1'b1, 12'h002, 256'hDEAD_BEEF, 1'b0, init_val(0)};
    vecs[2] = '{1'b0, 12'h002, 256'd0, 1'b0, 256'hDEAD_BEEF};
    vecs[3] = '{1'b0, 12'h00E, 256'd0, 1'b1, 256'hDEAD_BEEF};
    vecs[4] = '{1'b1, 12'h00D, {4{64'h0123_4567_89AB_CDEF}}, 1'b0, 256'hDEAD_BEEF};
    vecs[5] = '{1'b0, 12'h00D, 256'd0, 1'b0, {4{64'h0123_4567_89AB_CDEF}}};
    vecs[6] = '{1'b1, 12'hFFF, 256'h5A5A, 1'b1, {4{64'h0123_4567_89AB_CDEF}}};
    vecs[7] = '{1'b0, 12'h001, 256'd0, 1'b0, init_val(1)};

    nReset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_offset = 12'd0; req_wdata = 256'd0;
    repeat (3) @(posedge Clk);
    #1 check_reset_outputs("reset");
    @(negedge Clk) nReset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      r0 = rd_strobes; w0 = wr_strobes;
      issue(vecs[i].w, vecs[i].off, vecs[i].wd, acc);
      wait_rsp(d, e, c);
      check($sformatf("v%0d_err", i), 256'(e), 256'(vecs[i].exp_err));
      check($sformatf("v%0d_rdata", i), d, vecs[i].exp_rdata);
      check($sformatf("v%0d_latency", i), 256'(c - acc), 256'(LAT));
      check($sformatf("v%0d_rd_strobes", i), 256'(rd_strobes - r0),
            256'((!vecs[i].w && !vecs[i].exp_err) ? 1 : 0));
      check($sformatf("v%0d_wr_strobes", i), 256'(wr_strobes - w0),
            256'((vecs[i].w && !vecs[i].exp_err) ? 1 : 0));
      repeat (2) @(posedge Clk);
      check($sformatf("v%0d_no_dup_rsp", i), 256'(rsp_data_q.size()), 256'd0);
    end

`ifdef MAIN_MEM_INIT_QUEUE_EN
    s_w[0] = 1'b0; s_off[0] = 12'd10; s_wd[0] = 256'd0;
    s_w[1] = 1'b1; s_off[1] = 12'd3;  s_wd[1] = 256'hC0FFEE;
    s_w[2] = 1'b0; s_off[2] = 12'd3;  s_wd[2] = 256'd0;
    idx = 3;
`else
    s_w[0] = 1'b0; s_off[0] = 12'd10; s_wd[0] = 256'd0;
    s_w[1] = 1'b0; s_off[1] = 12'd11; s_wd[1] = 256'd0;
    s_w[2] = 1'b0; s_off[2] = 12'd0;  s_wd[2] = 256'd0;
    idx = 2;
`endif
    r0 = rd_strobes; w0 = wr_strobes;
    acc = 0;
    @(negedge Clk);
    for (int t = 0; t < 40 && acc < idx; t++) begin
      req_valid = 1'b1; req_write = s_w[acc]; req_offset = s_off[acc]; req_wdata = s_wd[acc];
      #1 rdy = int'(req_ready);
      @(posedge Clk);
      if (rdy != 0) begin
        s_acc[acc] = cyc;
        acc++;
      end
      #1;
    end
    check("stream_all_accepted", 256'(acc), 256'(idx));
`ifdef MAIN_MEM_INIT_QUEUE_EN
    check("queue_ready_full", 256'(req_ready), 256'd0);
    req_valid = 1'b0;
    check("queue_acc_gap0", 256'(s_acc[1] - s_acc[0]), 256'd1);
    check("queue_acc_gap1", 256'(s_acc[2] - s_acc[1]), 256'd1);
    wait_rsp(d, e, c);
    check("queue_rsp0", d, 256'h6);
    wait_rsp(d, e, c);
    check("queue_rsp1_rdata", d, 256'h6);
    check("queue_rsp1_err", 256'(e), 256'd0);
    wait_rsp(d, e, c);
    check("queue_rsp2", d, 256'hC0FFEE);
    check("queue_rd_strobes", 256'(rd_strobes - r0), 256'd2);
    check("queue_wr_strobes", 256'(wr_strobes - w0), 256'd1);
`else
    req_valid = 1'b0;
    check("b2b_acc_gap", 256'(s_acc[1] - s_acc[0]), 256'd2);
    wait_rsp(d, e, c);
    check("b2b_rsp0", d, 256'h6);
    wait_rsp(d, e, c);
    check("b2b_rsp1", d, 256'hd);
    check("b2b_rd_strobes", 256'(rd_strobes - r0), 256'd2);
`endif
    repeat (2) @(posedge Clk);
    check("stream_no_dup_rsp", 256'(rsp_data_q.size()), 256'd0);

    // Reset in the middle of a write strobe cycle.
    w0 = wr_strobes;
    issue(1'b1, 12'd5, 256'hBAD0_BAD0, acc);
    if (LAT == 3) @(posedge Clk);
    #1 check("mid_nWrite_low", 256'(nWrite), 256'd0);
    nReset = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (3) @(posedge Clk);
    check("reset_no_rsp", 256'(rsp_data_q.size()), 256'd0);
    check("reset_no_wr_strobe", 256'(wr_strobes - w0), 256'd0);
    @(negedge Clk) nReset = 1'b1;
    issue(1'b0, 12'd5, 256'd0, acc);
    wait_rsp(d, e, c);
    check("after_reset_read5", d, init_val(5));
    check("after_reset_err", 256'(e), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
